// File: rtl/dlx_pkg.sv
// Shared types, opcode constants and instruction field accessors for the DLX execute command path.
package dlx_pkg;

    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned REG_ADDR_WIDTH = 4;
    localparam int unsigned OPSEL_WIDTH    = 3;
    localparam int unsigned OP_WIDTH       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        WB    = 2'd3
    } state_e;

    // ALU class select
    localparam logic [OPSEL_WIDTH-1:0] SHLEFTLOG   = 3'b000;
    localparam logic [OPSEL_WIDTH-1:0] SHLEFTART   = 3'b001;
    localparam logic [OPSEL_WIDTH-1:0] SHRGHTLOG   = 3'b010;
    localparam logic [OPSEL_WIDTH-1:0] SHRGHTART   = 3'b011;
    localparam logic [OPSEL_WIDTH-1:0] ARITH_LOGIC = 3'b100;
    localparam logic [OPSEL_WIDTH-1:0] MEM_READ    = 3'b101;

    // ARITH_LOGIC operations
    localparam logic [OP_WIDTH-1:0] ADD  = 3'b000;
    localparam logic [OP_WIDTH-1:0] HADD = 3'b001;
    localparam logic [OP_WIDTH-1:0] SUB  = 3'b010;
    localparam logic [OP_WIDTH-1:0] NOT  = 3'b011;
    localparam logic [OP_WIDTH-1:0] AND  = 3'b100;
    localparam logic [OP_WIDTH-1:0] OR   = 3'b101;
    localparam logic [OP_WIDTH-1:0] XOR  = 3'b110;
    localparam logic [OP_WIDTH-1:0] LHG  = 3'b111;

    // MEM_READ operations
    localparam logic [OP_WIDTH-1:0] LOADBYTE  = 3'b000;
    localparam logic [OP_WIDTH-1:0] LOADHALF  = 3'b001;
    localparam logic [OP_WIDTH-1:0] LOADWORD  = 3'b011;
    localparam logic [OP_WIDTH-1:0] LOADBYTEU = 3'b100;
    localparam logic [OP_WIDTH-1:0] LOADHALFU = 3'b101;

    function automatic logic instr_imm_sel(input logic [INSTR_WIDTH-1:0] ins);
        return ins[31];
    endfunction

    function automatic logic [OPSEL_WIDTH-1:0] instr_opsel(input logic [INSTR_WIDTH-1:0] ins);
        return ins[30:28];
    endfunction

    function automatic logic [OP_WIDTH-1:0] instr_op(input logic [INSTR_WIDTH-1:0] ins);
        return ins[27:25];
    endfunction

    function automatic logic [REG_ADDR_WIDTH-1:0] instr_rd(input logic [INSTR_WIDTH-1:0] ins);
        return ins[24:21];
    endfunction

    function automatic logic [REG_ADDR_WIDTH-1:0] instr_rs1(input logic [INSTR_WIDTH-1:0] ins);
        return ins[20:17];
    endfunction

    function automatic logic [REG_ADDR_WIDTH-1:0] instr_rs2(input logic [INSTR_WIDTH-1:0] ins);
        return ins[15:12];
    endfunction

endpackage

// File: rtl/dlx_imm_ext.sv
// Immediate extender: zero-extends for logical ops and unsigned loads, sign-extends otherwise.
module dlx_imm_ext
    import dlx_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH  = 32,
    parameter int unsigned IMMEDIATE_WIDTH = 16
) (
    input  logic [OPSEL_WIDTH-1:0]     opsel,
    input  logic [OP_WIDTH-1:0]        op,
    input  logic [IMMEDIATE_WIDTH-1:0] imm,
    output logic [REGISTER_WIDTH-1:0]  ext_c
);

    localparam int unsigned PAD_WIDTH = REGISTER_WIDTH - IMMEDIATE_WIDTH;

    logic zero_ext;

    always_comb begin
        zero_ext = ((opsel == ARITH_LOGIC) && (op inside {AND, OR, XOR, LHG}))
                || ((opsel == MEM_READ) && (op inside {LOADBYTEU, LOADHALFU}));
        if (zero_ext) begin
            ext_c = {{PAD_WIDTH{1'b0}}, imm};
        end else begin
            ext_c = {{PAD_WIDTH{imm[IMMEDIATE_WIDTH-1]}}, imm};
        end
    end

endmodule

// File: rtl/dlx_issue_ctrl.sv
// DLX execute command path: accept one instruction, drive the ALU for one cycle, capture and write back.
// Optional sticky carry flag (carry_flag / carry_flag_clr) when DLX_STICKY_CARRY_EN is defined.
module dlx_issue_ctrl
    import dlx_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH  = 32,
    parameter int unsigned IMMEDIATE_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [INSTR_WIDTH-1:0]     instr,
    output logic [REG_ADDR_WIDTH-1:0]  rf_raddr1,
    output logic [REG_ADDR_WIDTH-1:0]  rf_raddr2,
    input  logic [REGISTER_WIDTH-1:0]  rf_rdata1,
    input  logic [REGISTER_WIDTH-1:0]  rf_rdata2,
    output logic                       enable_arith,
    output logic                       enable_shift,
    output logic [OPSEL_WIDTH-1:0]     opselect,
    output logic [OP_WIDTH-1:0]        operation,
    output logic [REGISTER_WIDTH-1:0]  aluin1,
    output logic [REGISTER_WIDTH-1:0]  aluin2,
    input  logic [REGISTER_WIDTH-1:0]  aluout,
    input  logic                       carry,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic                       wb_we,
    output logic [REG_ADDR_WIDTH-1:0]  wb_addr,
    output logic [REGISTER_WIDTH-1:0]  wb_data,
    output logic                       wb_carry,
    output logic                       wb_err
`ifdef DLX_STICKY_CARRY_EN
    ,
    output logic                       carry_flag,
    input  logic                       carry_flag_clr
`endif
);

    state_e                       state;
    logic [OPSEL_WIDTH-1:0]       opsel_f;
    logic [OP_WIDTH-1:0]          op_f;
    logic [IMMEDIATE_WIDTH-1:0]   imm_f;
    logic [REGISTER_WIDTH-1:0]    imm_ext_c;
    logic                         accept;
    logic                         is_illegal;
    logic                         is_shift;
    logic                         unused_instr_bit;

    assign rf_raddr1        = instr_rs1(instr);
    assign rf_raddr2        = instr_rs2(instr);
    assign opsel_f          = instr_opsel(instr);
    assign op_f             = instr_op(instr);
    assign imm_f            = instr[IMMEDIATE_WIDTH-1:0];
    assign accept           = instr_valid && instr_ready;
    assign is_illegal       = (opsel_f[2:1] == 2'b11);
    assign is_shift         = !opsel_f[2];
    assign unused_instr_bit = instr[16];

    dlx_imm_ext #(
        .REGISTER_WIDTH  (REGISTER_WIDTH),
        .IMMEDIATE_WIDTH (IMMEDIATE_WIDTH)
    ) u_imm_ext (
        .opsel (opsel_f),
        .op    (op_f),
        .imm   (imm_f),
        .ext_c (imm_ext_c)
    );

    // Issue FSM; illegal class skips the ALU and reports the error straight away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            enable_arith <= 1'b0;
            enable_shift <= 1'b0;
            opselect     <= '0;
            operation    <= '0;
            aluin1       <= '0;
            aluin2       <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            wb_carry     <= 1'b0;
            wb_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_ready <= 1'b0;
                        wb_addr     <= instr_rd(instr);
                        if (is_illegal) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= '0;
                            wb_carry <= 1'b0;
                            state    <= WB;
                        end else begin
                            opselect <= opsel_f;
                            aluin1   <= rf_rdata1;
                            if (is_shift) begin
                                enable_shift <= 1'b1;
                                operation    <= imm_f[OP_WIDTH-1:0];
                                aluin2       <= '0;
                            end else begin
                                enable_arith <= 1'b1;
                                operation    <= op_f;
                                aluin2       <= instr_imm_sel(instr) ? imm_ext_c : rf_rdata2;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    enable_arith <= 1'b0;
                    enable_shift <= 1'b0;
                    state        <= CAPT;
                end
                CAPT: begin
                    wb_data  <= aluout;
                    wb_carry <= carry;
                    wb_err   <= 1'b0;
                    wb_we    <= (wb_addr != '0);
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid    <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DLX_STICKY_CARRY_EN
    logic arith_used;

    // Remembers whether the in-flight op went through the arithmetic enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arith_used <= 1'b0;
        end else if ((state == IDLE) && accept) begin
            arith_used <= !is_shift && !is_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carry_flag <= 1'b0;
        end else if (carry_flag_clr) begin
            carry_flag <= 1'b0;
        end else if ((state == CAPT) && arith_used && carry) begin
            carry_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dlx_issue_ctrl.sv
// Self-checking bench for dlx_issue_ctrl: directed vector table, corner sequences and random ops
// checked against an instruction-level reference model; exercises the sticky carry when DLX_STICKY_CARRY_EN is set.
module tb_dlx_issue_ctrl;
    import dlx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic        enable_arith, enable_shift;
    logic [2:0]  opselect, operation;
    logic [31:0] aluin1, aluin2;
    logic [31:0] aluout = '0;
    logic        carry = 1'b0;
    logic        wb_valid, wb_we, wb_carry, wb_err;
    logic        wb_ready = 1'b0;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef DLX_STICKY_CARRY_EN
    logic        carry_flag;
    logic        carry_flag_clr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dlx_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .enable_arith (enable_arith),
        .enable_shift (enable_shift),
        .opselect     (opselect),
        .operation    (operation),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .aluout       (aluout),
        .carry        (carry),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_carry     (wb_carry),
        .wb_err       (wb_err)
`ifdef DLX_STICKY_CARRY_EN
        ,
        .carry_flag     (carry_flag),
        .carry_flag_clr (carry_flag_clr)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] d1;
        logic [31:0] d2;
        int          dly;
        logic        ill;
        logic        ea;
        logic        es;
        logic [2:0]  oper;
        logic [31:0] a2;
        logic [31:0] data;
        logic        cy;
        logic        we;
    } vec_t;

    // Behaviour of the external ALU: {carry, result}
    function automatic logic [32:0] alu_fn(input logic [2:0] sel, input logic [2:0] oper,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (sel)
            3'd0, 3'd1: r[31:0] = a << oper;
            3'd2:       r[31:0] = a >> oper;
            3'd3:       r[31:0] = 32'($signed(a) >>> oper);
            3'd4: begin
                case (oper)
                    3'd0, 3'd1: r = {1'b0, a} + {1'b0, b};
                    3'd2: begin r[31:0] = a - b; r[32] = (a < b); end
                    3'd3: r[31:0] = ~a;
                    3'd4: r[31:0] = a & b;
                    3'd5: r[31:0] = a | b;
                    3'd6: r[31:0] = a ^ b;
                    default: r[31:0] = {b[15:0], 16'h0000};
                endcase
            end
            3'd5:    r[31:0] = a + b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ALU with registered result, samples its operands while an enable is high
    always @(posedge clk) begin
        if (enable_arith || enable_shift) {carry, aluout} <= alu_fn(opselect, operation, aluin1, aluin2);
    end

    function automatic logic [31:0] mk(input logic i, input logic [2:0] opsel, input logic [2:0] op,
                                       input logic [3:0] rd, input logic [3:0] rs1, input logic [15:0] imm);
        return {i, opsel, op, rd, rs1, 1'b0, imm};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                                 input int dly, input logic ill, input logic ea, input logic es,
                                 input logic [2:0] oper, input logic [31:0] a2, input logic [31:0] data,
                                 input logic cy, input logic we);
        vec_t v;
        v.ins = ins; v.d1 = d1; v.d2 = d2; v.dly = dly; v.ill = ill; v.ea = ea; v.es = es;
        v.oper = oper; v.a2 = a2; v.data = data; v.cy = cy; v.we = we;
        return v;
    endfunction

    // Instruction-level reference: what the writeback should carry for a given instruction and operands
    function automatic vec_t ref_vec(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                                     input int dly);
        vec_t v;
        int unsigned opsel, op, imm;
        logic [32:0] r;
        bit zext;
        opsel = 32'(ins[30:28]);
        op    = 32'(ins[27:25]);
        imm   = 32'(ins[15:0]);
        v.ins = ins; v.d1 = d1; v.d2 = d2; v.dly = dly;
        v.ill = (opsel >= 6);
        v.es  = (opsel < 4);
        v.ea  = (opsel == 4) || (opsel == 5);
        v.oper = v.es ? 3'(imm % 8) : 3'(op);
        zext = ((opsel == 4) && (op >= 4)) || ((opsel == 5) && ((op == 4) || (op == 5)));
        if (v.es)                    v.a2 = 32'd0;
        else if (!ins[31])           v.a2 = d2;
        else if (zext || imm < 32768) v.a2 = imm;
        else                         v.a2 = imm + 32'hFFFF_0000;
        r = v.ill ? 33'd0 : alu_fn(3'(opsel), v.oper, d1, v.a2);
        v.data = r[31:0];
        v.cy   = r[32];
        v.we   = !v.ill && (ins[24:21] != 4'd0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full transaction starting and ending on a negedge
    task automatic do_instr(input vec_t v);
        logic [31:0] wd;
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("ready_wait", 64'(instr_ready), 64'd1);
        instr = v.ins; rf_rdata1 = v.d1; rf_rdata2 = v.d2; instr_valid = 1'b1;
        #1;
        chk("raddr1", 64'(rf_raddr1), 64'(v.ins[20:17]));
        chk("raddr2", 64'(rf_raddr2), 64'(v.ins[15:12]));
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_busy", 64'(instr_ready), 64'd0);
        if (!v.ill) begin
            chk("en_arith", 64'(enable_arith), 64'(v.ea));
            chk("en_shift", 64'(enable_shift), 64'(v.es));
            chk("opselect", 64'(opselect), 64'(v.ins[30:28]));
            chk("operation", 64'(operation), 64'(v.oper));
            chk("aluin1", 64'(aluin1), 64'(v.d1));
            chk("aluin2", 64'(aluin2), 64'(v.a2));
            chk("wb_valid_issue", 64'(wb_valid), 64'd0);
            @(negedge clk);
            chk("en_capt", 64'({enable_arith, enable_shift}), 64'd0);
            chk("wb_valid_capt", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end else begin
            chk("en_illegal", 64'({enable_arith, enable_shift}), 64'd0);
        end
        chk("wb_valid", 64'(wb_valid), 64'd1);
        chk("wb_data", 64'(wb_data), 64'(v.data));
        chk("wb_carry", 64'(wb_carry), 64'(v.cy));
        chk("wb_err", 64'(wb_err), 64'(v.ill));
        chk("wb_we", 64'(wb_we), 64'(v.we));
        chk("wb_addr", 64'(wb_addr), 64'(v.ins[24:21]));
        wd = wb_data;
        repeat (v.dly) begin
            @(negedge clk);
            chk("hold_valid", 64'(wb_valid), 64'd1);
            chk("hold_data", 64'(wb_data), 64'(wd));
            chk("hold_addr", 64'(wb_addr), 64'(v.ins[24:21]));
            chk("hold_ready", 64'(instr_ready), 64'd0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("wb_release", 64'(wb_valid), 64'd0);
        chk("ready_back", 64'(instr_ready), 64'd1);
    endtask

    initial begin
        vec_t tbl[12];
        vec_t rv;
        logic [31:0] rins;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_en", 64'({enable_arith, enable_shift}), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_opselect", 64'({opselect, operation}), 64'd0);
        chk("rst_aluin", 64'({aluin1, aluin2}), 64'd0);
        chk("rst_wb_data", 64'({wb_data, wb_we, wb_err, wb_carry, wb_addr}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(instr_ready), 64'd1);

        //             ins                                             d1            d2        dly ill ea es oper  a2             data           cy we
        tbl[0]  = mkv(mk(0, ARITH_LOGIC, ADD, 4'd3, 4'd1, 16'h2000), 32'd5,        32'd7,    0, 0, 1, 0, ADD, 32'd7,        32'd12,        0, 1);
        tbl[1]  = mkv(mk(1, ARITH_LOGIC, ADD, 4'd4, 4'd1, 16'hFFFF), 32'd1,        32'h55,   1, 0, 1, 0, ADD, 32'hFFFFFFFF, 32'd0,         1, 1);
        tbl[2]  = mkv(mk(1, ARITH_LOGIC, AND, 4'd5, 4'd1, 16'hFFFF), 32'd1,        32'h55,   0, 0, 1, 0, AND, 32'h0000FFFF, 32'd1,         0, 1);
        tbl[3]  = mkv(mk(0, SHLEFTLOG,   ADD, 4'd6, 4'd1, 16'h0003), 32'd1,        32'h99,   0, 0, 0, 1, 3'd3, 32'd0,       32'd8,         0, 1);
        tbl[4]  = mkv(mk(0, 3'b110,      ADD, 4'd7, 4'd1, 16'h2000), 32'd5,        32'd7,    1, 1, 0, 0, 3'd0, 32'd0,       32'd0,         0, 0);
        tbl[5]  = mkv(mk(0, ARITH_LOGIC, ADD, 4'd0, 4'd1, 16'h2000), 32'd2,        32'd3,    5, 0, 1, 0, ADD, 32'd3,        32'd5,         0, 0);
        tbl[6]  = mkv(mk(1, MEM_READ, LOADBYTEU, 4'd8, 4'd2, 16'h8004), 32'h100,   32'd0,    0, 0, 1, 0, LOADBYTEU, 32'h00008004, 32'h00008104, 0, 1);
        tbl[7]  = mkv(mk(1, MEM_READ, LOADWORD,  4'd8, 4'd2, 16'h8004), 32'h100,   32'd0,    0, 0, 1, 0, LOADWORD,  32'hFFFF8004, 32'hFFFF8104, 0, 1);
        tbl[8]  = mkv(mk(0, SHRGHTART,   ADD, 4'd9, 4'd3, 16'h0004), 32'h80000000, 32'd1,    0, 0, 0, 1, 3'd4, 32'd0,       32'hF8000000,  0, 1);
        tbl[9]  = mkv(mk(0, 3'b111,      SUB, 4'd0, 4'd3, 16'h1234), 32'd9,        32'd9,    2, 1, 0, 0, 3'd0, 32'd0,       32'd0,         0, 0);
        tbl[10] = mkv(mk(1, ARITH_LOGIC, XOR, 4'd11, 4'd4, 16'hF0F0), 32'hFFFF0000, 32'd0,   0, 0, 1, 0, XOR, 32'h0000F0F0, 32'hFFFFF0F0,  0, 1);
        tbl[11] = mkv(mk(0, ARITH_LOGIC, SUB, 4'd12, 4'd4, 16'h5000), 32'd3,       32'd5,    0, 0, 1, 0, SUB, 32'd5,        32'hFFFFFFFE,  1, 1);

        for (int i = 0; i < 12; i++) do_instr(tbl[i]);

`ifdef DLX_STICKY_CARRY_EN
        chk("flag_set", 64'(carry_flag), 64'd1);
        carry_flag_clr = 1'b1;
        @(negedge clk);
        chk("flag_clr", 64'(carry_flag), 64'd0);
        do_instr(tbl[1]);
        carry_flag_clr = 1'b0;
        chk("flag_clr_wins", 64'(carry_flag), 64'd0);
        do_instr(tbl[3]);
        chk("flag_shift", 64'(carry_flag), 64'd0);
        do_instr(tbl[1]);
        chk("flag_reset_set", 64'(carry_flag), 64'd1);
`endif

        // New instruction held through WB is taken only on the cycle after the handshake
        instr = mk(0, ARITH_LOGIC, ADD, 4'd9, 4'd1, 16'h2000);
        rf_rdata1 = 32'd10; rf_rdata2 = 32'd20; instr_valid = 1'b1;
        @(negedge clk);
        instr = mk(0, ARITH_LOGIC, SUB, 4'd10, 4'd1, 16'h2000);
        rf_rdata1 = 32'd9; rf_rdata2 = 32'd4;
        chk("bb_first_op", 64'({enable_arith, operation, aluin1}), 64'({1'b1, ADD, 32'd10}));
        @(negedge clk);
        chk("bb_capt_ready", 64'(instr_ready), 64'd0);
        @(negedge clk);
        chk("bb_first_wb", 64'({wb_valid, wb_addr, wb_data}), 64'({1'b1, 4'd9, 32'd30}));
        @(negedge clk);
        chk("bb_busy_ignored", 64'({wb_valid, instr_ready, enable_arith}), 64'({1'b1, 1'b0, 1'b0}));
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("bb_after_hs", 64'({wb_valid, instr_ready, enable_arith}), 64'({1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        instr_valid = 1'b0;
        chk("bb_second_op", 64'({enable_arith, operation, aluin1, aluin2[3:0]}), 64'({1'b1, SUB, 32'd9, 4'd4}));
        repeat (2) @(negedge clk);
        chk("bb_second_wb", 64'({wb_valid, wb_addr, wb_data}), 64'({1'b1, 4'd10, 32'd5}));
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;

        // Reset while the ALU enable is high aborts the op
        instr = mk(0, ARITH_LOGIC, ADD, 4'd3, 4'd1, 16'h2000);
        rf_rdata1 = 32'd5; rf_rdata2 = 32'd7; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("abort_issue", 64'(enable_arith), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_en", 64'({enable_arith, enable_shift}), 64'd0);
        chk("abort_wb", 64'(wb_valid), 64'd0);
`ifdef DLX_STICKY_CARRY_EN
        chk("abort_flag", 64'(carry_flag), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_wb", 64'(wb_valid), 64'd0);
        end
        chk("abort_ready", 64'(instr_ready), 64'd1);

        for (int k = 0; k < 40; k++) begin
            rins = $urandom;
            rv = ref_vec(rins, $urandom, $urandom, int'($urandom_range(0, 3)));
            do_instr(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
